vga_capture: RTL

VGA receiver/capture block: the sink end of the VGA link driven by VGAInterface.
- Samples vga_hsync/vga_vsync/vga_r/g/b, recovers horizontal and vertical timing, and locks onto a frame with the parameterised geometry.
- Emits one framebuffer write per visible pixel.
- Used for loopback verification of the VGA transmitter and as a capture front-end.

---
 rtl/vga_capture.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vga_capture.sv
// VGA sink: recovers sync timing, locks onto the frame
// and emits one framebuffer write per visible pixel.
module vga_capture #(
  parameter int HAddrSize     = 11,
  parameter int HVisibleArea  = 640,
  parameter int HFrontPorch   = 16,
  parameter int HSyncPulse    = 96,
  parameter int HBackPorch    = 48,
  parameter int VAddrSize     = 11,
  parameter int VVisibleArea  = 480,
  parameter int VFrontPorch   = 10,
  parameter int VSyncPulse    = 2,
  parameter int VBackPorch    = 33,
  parameter int SyncActiveLow = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 vga_hsync,
  input  logic                 vga_vsync,
  input  logic                 vga_r,
  input  logic                 vga_g,
  input  logic                 vga_b,
  output logic                 fb_write,
  output logic [HAddrSize-1:0] fb_addr_h,
  output logic [VAddrSize-1:0] fb_addr_v,
  output logic                 fb_data_r,
  output logic                 fb_data_g,
  output logic                 fb_data_b,
  output logic                 locked,
  output logic                 frame_done,
  output logic                 sync_error
);

  localparam int HTotal = HVisibleArea + HFrontPorch
                        + HSyncPulse + HBackPorch;
  localparam int VTotal = VVisibleArea + VFrontPorch
                        + VSyncPulse + VBackPorch;
  localparam int HStart = HSyncPulse + HBackPorch;
  localparam int VStart = VSyncPulse + VBackPorch;

  localparam logic [HAddrSize-1:0] HTotM1 =
    HAddrSize'(HTotal - 1);
  localparam logic [HAddrSize-1:0] HTot =
    HAddrSize'(HTotal);
  localparam logic [HAddrSize-1:0] HSat =
    HAddrSize'(HTotal + 1);
  localparam logic [HAddrSize-1:0] HSyn =
    HAddrSize'(HSyncPulse);
  localparam logic [HAddrSize-1:0] HBeg =
    HAddrSize'(HStart);
  localparam logic [HAddrSize-1:0] HEnd =
    HAddrSize'(HStart + HVisibleArea);
  localparam logic [VAddrSize-1:0] VTotM1 =
    VAddrSize'(VTotal - 1);
  localparam logic [VAddrSize-1:0] VTot =
    VAddrSize'(VTotal);
  localparam logic [VAddrSize-1:0] VBeg =
    VAddrSize'(VStart);
  localparam logic [VAddrSize-1:0] VEnd =
    VAddrSize'(VStart + VVisibleArea);

  // Idle (deasserted) level of both sync lines
  localparam logic SyncOff = (SyncActiveLow != 0);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  state_t state;

  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;
  logic [2:0]           rgb_q;
  logic [HAddrSize-1:0] hcount, hc_nxt;
  logic [VAddrSize-1:0] vcount, vc_nxt;
  logic                 hs_rise, hs_fall, vs_rise;
  logic                 viol, vis;

  assign hs_rise = (hs_q != SyncOff) && (hs_d == SyncOff);
  assign hs_fall = (hs_q == SyncOff) && (hs_d != SyncOff);
  assign vs_rise = (vs_q != SyncOff) && (vs_d == SyncOff);

  always_comb begin
    hc_nxt = hcount;
    if (hs_rise)
      hc_nxt = '0;
    else if (hcount != HSat)
      hc_nxt = hcount + HAddrSize'(1);
    vc_nxt = vcount;
    if (vs_rise)
      vc_nxt = '0;
    else if (hs_rise && vcount != VTot)
      vc_nxt = vcount + VAddrSize'(1);
  end

  always_comb begin
    viol = 1'b0;
    if (state != SEARCH)
      viol = (hs_rise && hcount != HTotM1)
          || (hs_fall && hc_nxt != HSyn)
          || (!hs_rise && hcount == HTot)
          || (vs_rise && vcount != VTotM1)
          || (hs_rise && !vs_rise
              && vcount == VTotM1);
  end

  assign vis = (hc_nxt >= HBeg) && (hc_nxt < HEnd)
            && (vc_nxt >= VBeg) && (vc_nxt < VEnd);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_q       <= SyncOff;
      hs_d       <= SyncOff;
      vs_q       <= SyncOff;
      vs_d       <= SyncOff;
      rgb_q      <= '0;
      hcount     <= '0;
      vcount     <= '0;
      state      <= SEARCH;
      fb_write   <= 1'b0;
      fb_addr_h  <= '0;
      fb_addr_v  <= '0;
      fb_data_r  <= 1'b0;
      fb_data_g  <= 1'b0;
      fb_data_b  <= 1'b0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      hs_q       <= vga_hsync;
      hs_d       <= hs_q;
      vs_q       <= vga_vsync;
      vs_d       <= vs_q;
      rgb_q      <= {vga_r, vga_g, vga_b};
      hcount     <= hc_nxt;
      vcount     <= vc_nxt;
      sync_error <= viol;
      frame_done <= 1'b0;
      fb_write   <= 1'b0;
      unique case (state)
        SEARCH: begin
          if (vs_rise)
            state <= VERIFY;
        end
        VERIFY: begin
          if (viol) begin
            state <= SEARCH;
          end else if (vs_rise) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (viol) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end else begin
            frame_done <= vs_rise;
            if (vis) begin
              fb_write  <= 1'b1;
              fb_addr_h <= hc_nxt - HBeg;
              fb_addr_v <= vc_nxt - VBeg;
              fb_data_r <= rgb_q[2];
              fb_data_g <= rgb_q[1];
              fb_data_b <= rgb_q[0];
            end
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule
